pll_lock_seq: RTL and testbench

PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

---
 rtl/pll_seq_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/pll_lock_seq.sv | 119 +++++++++++
 tb/tb_pll_lock_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL lock sequencer.
package pll_seq_pkg;

  localparam int STATE_W = 3;
  localparam int LOSS_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABILIZE  = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4
  } pll_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_seq.sv
// PLL reset/lock sequencer with retry, timeout and fault handling.
// Define PLL_LOCK_SEQ_LOSS_CNT_EN to build the lock-loss event counter.
import pll_seq_pkg::*;

module pll_lock_seq #(
  parameter int RST_HOLD_CYCLES     = 50,
  parameter int LOCK_STABLE_CYCLES  = 5000,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               restart,
  output logic               pll_rst,
  output logic               ready,
  output logic               fault,
  output logic [1:0]         retry_cnt,
  output logic [STATE_W-1:0] state,
  output logic [LOSS_W-1:0]  loss_cnt
);

  localparam int MAX_CYC = max3(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    MAX_R     = 2'(MAX_RETRIES);

  logic          locked_s;
  pll_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    retry_q, retry_d, retry_inc;
  logic          pll_rst_q, ready_q, fault_q;

  sync_2ff u_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    retry_inc = retry_q + 2'd1;
    if (restart) begin
      state_d = ST_RESET_HOLD;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET_HOLD: if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABILIZE;
          end else if (cnt_q == TMO_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == MAX_R) ? ST_FAULT : ST_RESET_HOLD;
          end
        end
        ST_STABILIZE: begin
          if (!locked_s)               state_d = ST_WAIT_LOCK;
          else if (cnt_q == STAB_LAST) state_d = ST_RUN;
        end
        ST_RUN:   if (!locked_s) state_d = ST_RESET_HOLD;
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_RESET_HOLD;
      endcase
    end
    if (state_d == ST_RUN && state_q != ST_RUN) retry_d = '0;
    // Restart re-enters RESET_HOLD even from RESET_HOLD, so it restarts the hold count.
    if (restart || state_d != state_q) cnt_d = '0;
    else if (cnt_q != '1)              cnt_d = cnt_q + CW'(1);
    else                               cnt_d = cnt_q;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_RESET_HOLD;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= (state_d == ST_RESET_HOLD) || (state_d == ST_FAULT);
      ready_q   <= (state_d == ST_RUN);
      fault_q   <= (state_d == ST_FAULT);
    end
  end

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  logic              loss_ev;
  logic [LOSS_W-1:0] loss_q;

  // A restart in RUN is a deliberate resequence, not a lock loss.
  assign loss_ev = (state_q == ST_RUN) && !locked_s && !restart;

  always_ff @(posedge refclk) begin
    if (rst)                        loss_q <= '0;
    else if (loss_ev && loss_q != '1) loss_q <= loss_q + LOSS_W'(1);
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = '0;
`endif

  assign pll_rst   = pll_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq with short cycle parameters.
import pll_seq_pkg::*;

module tb_pll_lock_seq;

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  localparam int EXP_LOSS = 1;
`else
  localparam int EXP_LOSS = 0;
`endif

  logic               refclk = 1'b0;
  logic               rst, pll_locked, restart;
  logic               pll_rst, ready, fault;
  logic [1:0]         retry_cnt;
  logic [STATE_W-1:0] state;
  logic [LOSS_W-1:0]  loss_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  pll_lock_seq #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .state      (state),
    .loss_cnt   (loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [STATE_W-1:0] s, input int bound);
    for (int i = 0; i < bound && state !== s; i++) tick();
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic count_while_state(input logic [STATE_W-1:0] s, output int cnt);
    cnt = 0;
    while (state === s && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; pll_locked = 1'b0; restart = 1'b0;
    repeat (3) tick();
    chk("rst_state", 32'(state), 32'(ST_RESET_HOLD));
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_retry", 32'(retry_cnt), 0);
    chk("rst_loss", 32'(loss_cnt), 0);

    // Normal bring-up: hold, lock two cycles into WAIT_LOCK, ready 11 cycles later.
    rst = 1'b0;
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("hold_len", n, 4);
    chk("hold_to_wl", 32'(state), 32'(ST_WAIT_LOCK));
    repeat (2) tick();
    pll_locked = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("ready_lat", n, 11);
    chk("run_state", 32'(state), 32'(ST_RUN));
    chk("run_pll_rst", 32'(pll_rst), 0);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    repeat (2) tick();
    chk("loss_ready_hold", 32'(ready), 1);
    tick();
    chk("loss_ready_fall", 32'(ready), 0);
    chk("loss_state", 32'(state), 32'(ST_RESET_HOLD));
    chk("loss_cnt", 32'(loss_cnt), EXP_LOSS);
    pll_locked = 1'b1;
    wait_state("reseq_run", ST_RUN, 40);
    chk("reseq_ready", 32'(ready), 1);

    // Glitch at STABILIZE cycle 5 sends the FSM back to WAIT_LOCK.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_state", 32'(state), 32'(ST_RESET_HOLD));
    chk("rs_loss_kept", 32'(loss_cnt), EXP_LOSS);
    wait_state("gl_stab", ST_STABILIZE, 20);
    repeat (5) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    chk("gl_still_stab", 32'(state), 32'(ST_STABILIZE));
    tick();
    chk("gl_back_wl", 32'(state), 32'(ST_WAIT_LOCK));
    chk("gl_ready0", 32'(ready), 0);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("gl_fresh_lat", n, 9);

    // Two timeouts lead to FAULT.
    pll_locked = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    wait_state("to1_wl", ST_WAIT_LOCK, 20);
    count_while_state(ST_WAIT_LOCK, n);
    chk("to1_len", n, 32);
    chk("to1_state", 32'(state), 32'(ST_RESET_HOLD));
    chk("to1_retry", 32'(retry_cnt), 1);
    chk("to1_pll_rst", 32'(pll_rst), 1);
    wait_state("to2_wl", ST_WAIT_LOCK, 20);
    count_while_state(ST_WAIT_LOCK, n);
    chk("to2_len", n, 32);
    chk("flt_state", 32'(state), 32'(ST_FAULT));
    chk("flt_retry", 32'(retry_cnt), 2);
    chk("flt_fault", 32'(fault), 1);
    chk("flt_pll_rst", 32'(pll_rst), 1);
    chk("flt_ready", 32'(ready), 0);
    repeat (5) tick();
    chk("flt_sticky", 32'(state), 32'(ST_FAULT));
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("flt_rs_state", 32'(state), 32'(ST_RESET_HOLD));
    chk("flt_rs_retry", 32'(retry_cnt), 0);
    chk("flt_rs_fault", 32'(fault), 0);
    chk("flt_rs_pll_rst", 32'(pll_rst), 1);

    // Restart coincides with the timeout cycle: restart wins.
    wait_state("rt_wl", ST_WAIT_LOCK, 20);
    repeat (31) tick();
    chk("rt_pre", 32'(state), 32'(ST_WAIT_LOCK));
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rt_state", 32'(state), 32'(ST_RESET_HOLD));
    chk("rt_retry", 32'(retry_cnt), 0);
    chk("rt_fault", 32'(fault), 0);

    // rst mid-STABILIZE abandons the sequence.
    pll_locked = 1'b1;
    wait_state("mr_stab", ST_STABILIZE, 40);
    repeat (3) tick();
    chk("mr_pre", 32'(state), 32'(ST_STABILIZE));
    rst = 1'b1;
    tick();
    chk("mr_state", 32'(state), 32'(ST_RESET_HOLD));
    chk("mr_pll_rst", 32'(pll_rst), 1);
    chk("mr_ready", 32'(ready), 0);
    chk("mr_fault", 32'(fault), 0);
    chk("mr_retry", 32'(retry_cnt), 0);
    chk("mr_loss", 32'(loss_cnt), 0);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
